// File: rtl/mips32_mem_pkg.sv
// Shared constants and FSM state type for the MIPS32 memory responder.
package mips32_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] HLT_OP = 32'hfc000000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/mips32_mem_array.sv
// Word storage: one write port (host preload wins over pipeline write), one registered read port.
module mips32_mem_array
  import mips32_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_idx,
  input  logic [WORD_W-1:0] ld_data,
  input  logic              we,
  input  logic [AW-1:0]     w_idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     r_idx,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Contents are deliberately never reset; rdata only moves on a read so it holds a captured response.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_idx] <= ld_data;
    end else if (we) begin
      mem[w_idx] <= wdata;
    end
    if (re) begin
      rdata <= mem[r_idx];
    end
  end

endmodule

// File: rtl/mips32_mem_responder.sv
// Single-outstanding memory responder with configurable response latency.
// Define MIPS32_MEM_ERR_EN to flag out-of-range addresses instead of wrapping them.
module mips32_mem_responder
  import mips32_mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              ld_en,
  input  logic [WORD_W-1:0] ld_addr,
  input  logic [WORD_W-1:0] ld_data
);

  localparam int unsigned AW      = $clog2(MEM_DEPTH);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  state_t            state, state_nx;
  logic [3:0]        cnt, cnt_nx;
  logic              up;
  logic              cap_we, cap_err;
  logic              accept, req_oor, ld_ok;
  logic [WORD_W-1:0] rd_word;

`ifdef MIPS32_MEM_ERR_EN
  assign req_oor = |req_addr[WORD_W-1:AW];
  assign ld_ok   = ld_en && !(|ld_addr[WORD_W-1:AW]);
`else
  logic unused_hi;
  assign unused_hi = ^{req_addr[WORD_W-1:AW], ld_addr[WORD_W-1:AW]};
  assign req_oor   = 1'b0;
  assign ld_ok     = ld_en;
`endif

  assign accept = req_valid && req_ready;

  mips32_mem_array #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .ld_en   (ld_ok),
    .ld_idx  (ld_addr[AW-1:0]),
    .ld_data (ld_data),
    .we      (accept && req_we && !req_oor),
    .w_idx   (req_addr[AW-1:0]),
    .wdata   (req_wdata),
    .re      (accept && !req_we),
    .r_idx   (req_addr[AW-1:0]),
    .rdata   (rd_word)
  );

  // up keeps req_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      up      <= 1'b0;
      cap_we  <= 1'b0;
      cap_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      up    <= 1'b1;
      if (accept) begin
        cap_we  <= req_we;
        cap_err <= req_oor;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
            cnt_nx   = WAIT_LD;
          end
        end
      end
      WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready = up && (state == IDLE) && !ld_en;
    rsp_valid = (state == RESP);
    rsp_err   = (state == RESP) && cap_err;
    rsp_rdata = ((state == RESP) && !cap_we && !cap_err) ? rd_word : '0;
  end

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Randomized bench for mips32_mem_responder against an array-based memory model.
module tb_mips32_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WAITC = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0, ld_en = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, ld_addr = '0, ld_data = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [DEPTH];

  mips32_mem_responder #(
    .MEM_DEPTH   (DEPTH),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit oor(input logic [31:0] a);
`ifdef MIPS32_MEM_ERR_EN
    return a >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = 32'($urandom_range(DEPTH - 1));
    if ($urandom_range(7) == 0) a = a | (32'd1 << $urandom_range(31, 10));
    return a;
  endfunction

  // One clock; applies any host preload to the model, then drops ld_en.
  task automatic tick();
    @(posedge clk);
    if (ld_en && !oor(ld_addr)) model[ld_addr % DEPTH] = ld_data;
    @(negedge clk);
    ld_en = 1'b0;
    #1;
  endtask

  task automatic maybe_ld(input logic [31:0] addr);
    if ($urandom_range(2) == 0) begin
      ld_en   = 1'b1;
      ld_addr = ($urandom_range(1) == 0) ? addr : rnd_addr();
      ld_data = $urandom;
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    tick();
    tick();
    check("rst_hold_valid", rsp_valid, 0);
    rst_n = 1'b1;
    #1;
    check("ready_before_clock", req_ready, 0);
    tick();
    check("ready_after_reset", req_ready, 1);
    check("valid_after_reset", rsp_valid, 0);
  endtask

  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int hold, input bit ld_block, input bit mid_ld, input bit abort);
    logic [31:0] exp_d;
    logic        exp_e;
    int          n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    if (ld_block) begin
      ld_en   = 1'b1;
      ld_addr = rnd_addr();
      ld_data = $urandom;
      #1;
      check("ld_blocks_ready", req_ready, 0);
      tick();
      check("ready_after_ld", req_ready, 1);
    end
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check("accept_timeout", 32'(n < 20), 1);
    exp_e = oor(addr);
    exp_d = (we || exp_e) ? 32'd0 : model[addr % DEPTH];
    tick();
    if (we && !exp_e) model[addr % DEPTH] = wdata;
    req_valid = 1'b0;
    if (abort) begin
      reset_pulse();
      return;
    end
    n = 1;
    while (!rsp_valid && n < 40) begin
      check("busy_ready", req_ready, 0);
      if (mid_ld) maybe_ld(addr);
      tick();
      n++;
    end
    check("latency", n, 1 + WAITC);
    repeat (hold) begin
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_rdata, exp_d);
      check("hold_err", rsp_err, exp_e);
      check("hold_ready", req_ready, 0);
      if (mid_ld) maybe_ld(addr);
      tick();
    end
    rsp_ready = 1'b1;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_data", rsp_rdata, exp_d);
    check("rsp_err", rsp_err, exp_e);
    tick();
    rsp_ready = 1'b0;
    check("rsp_dropped", rsp_valid, 0);
    check("ready_after_rsp", req_ready, 1);
  endtask

  initial begin
    #2;
    reset_pulse();

    for (int i = 0; i < DEPTH; i++) begin
      ld_en   = 1'b1;
      ld_addr = 32'(i);
      ld_data = $urandom;
      tick();
    end
    ld_en = 1'b1; ld_addr = 32'd0; ld_data = 32'h2801000a; tick();
    ld_en = 1'b1; ld_addr = 32'd8; ld_data = 32'hfc000000; tick();

    // Program image readback, with a stalled response on the second read.
    do_req(1'b0, 32'd0, 32'd0, 0, 1'b0, 1'b0, 1'b0);
    check("prog_word0", model[0], 32'h2801000a);
    do_req(1'b0, 32'd8, 32'd0, 2, 1'b0, 1'b0, 1'b0);

    do_req(1'b1, 32'd4, 32'h0000001e, 1, 1'b0, 1'b0, 1'b0);
    do_req(1'b0, 32'd4, 32'd0, 0, 1'b0, 1'b0, 1'b0);

    do_req(1'b1, 32'd1024, 32'h12345678, 0, 1'b0, 1'b0, 1'b0);
    do_req(1'b0, 32'd1024, 32'd0, 1, 1'b0, 1'b0, 1'b0);
    do_req(1'b0, 32'd0, 32'd0, 0, 1'b0, 1'b0, 1'b0);

    do_req(1'b0, 32'd8, 32'd0, 0, 1'b1, 1'b0, 1'b0);

    // Reset in WAIT after a write: write survives, no response is produced.
    do_req(1'b1, 32'd12, 32'hdeadbeef, 0, 1'b0, 1'b0, 1'b1);
    do_req(1'b0, 32'd12, 32'd0, 0, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 80; t++) begin
      do_req(1'($urandom_range(1)), rnd_addr(), $urandom, int'($urandom_range(3)),
             ($urandom_range(5) == 0), ($urandom_range(2) == 0), ($urandom_range(15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
